// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS main control FSM. Each instruction runs through fetch,
// decode, execute, memory and writeback states. The FSM drives the datapath
// mux selects and enables, and it waits on a memory ready handshake that has
// a timeout.
// Optional build macro: MC_CTRL_ILLEGAL_TRAP_EN. When it is defined, an
// unknown opcode goes to the TRAP state. When it is undefined, an unknown
// opcode retires as a no-op in DECODE.
module multicycle_control_unit #(
   parameter int                  OPCODE_W    = 6,
   parameter logic [OPCODE_W-1:0] OP_RTYPE    = 6'h00,
   parameter logic [OPCODE_W-1:0] OP_LW       = 6'h23,
   parameter logic [OPCODE_W-1:0] OP_SW       = 6'h2B,
   parameter logic [OPCODE_W-1:0] OP_BEQ      = 6'h04,
   parameter logic [OPCODE_W-1:0] OP_ADDI     = 6'h08,
   parameter logic [OPCODE_W-1:0] OP_J        = 6'h02,
   parameter int                  MEM_TIMEOUT = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [OPCODE_W-1:0] opcode,
   input  logic                mem_ready,
   output logic                pc_write,
   output logic                pc_write_cond,
   output logic [1:0]          pc_source,
   output logic                i_or_d,
   output logic                mem_read,
   output logic                mem_write,
   output logic                ir_write,
   output logic                mem_to_reg,
   output logic                reg_dst,
   output logic                reg_write,
   output logic                alu_src_a,
   output logic [1:0]          alu_src_b,
   output logic [1:0]          alu_op,
   output logic                instr_done,
   output logic                bus_error,
   output logic                illegal_op,
   output logic [3:0]          state_o
);

   typedef enum logic [3:0] {
      S_IDLE      = 4'd0,
      S_FETCH     = 4'd1,
      S_DECODE    = 4'd2,
      S_MEM_ADDR  = 4'd3,
      S_MEM_READ  = 4'd4,
      S_MEM_WB    = 4'd5,
      S_MEM_WRITE = 4'd6,
      S_EXECUTE   = 4'd7,
      S_R_WB      = 4'd8,
      S_BRANCH    = 4'd9,
      S_JUMP      = 4'd10,
      S_ADDI_EXEC = 4'd11,
      S_ADDI_WB   = 4'd12,
      S_TRAP      = 4'd13
   } state_t;

   // A timeout of 0 still needs a 1-bit counter. That counter then just saturates.
   localparam int             CNT_W     = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MEM_TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] wait_cnt, wait_cnt_nxt;
   logic             in_mem_state;
   logic             timeout;

   assign state_o      = state;
   assign in_mem_state = (state == S_FETCH) || (state == S_MEM_READ) || (state == S_MEM_WRITE);
   // A ready that arrives in the limit cycle counts as completion, not as a timeout.
   assign timeout      = (MEM_TIMEOUT != 0) && in_mem_state && !mem_ready && (wait_cnt == CNT_LIMIT);

   // State register and wait counter. Reset abandons any instruction in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_IDLE;
         wait_cnt <= '0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_cnt_nxt;
      end
   end

   // Wait counter: it counts consecutive not-ready cycles and restarts on every state entry.
   always_comb begin
      wait_cnt_nxt = '0;
      if (in_mem_state && !mem_ready && (state_nxt == state)) begin
         wait_cnt_nxt = (wait_cnt != CNT_MAX) ? wait_cnt + 1'b1 : wait_cnt;
      end
   end

   // Next-state and Moore output decode. Only the FETCH and MEM_WRITE outputs also look at mem_ready.
   always_comb begin
      state_nxt     = state;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      pc_source     = 2'b00;
      i_or_d        = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      mem_to_reg    = 1'b0;
      reg_dst       = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      alu_op        = 2'b00;
      instr_done    = 1'b0;
      bus_error     = 1'b0;
      illegal_op    = 1'b0;
      case (state)
         S_IDLE: state_nxt = S_FETCH;
         S_FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = 2'b01;
            if (mem_ready) begin
               ir_write  = 1'b1;
               pc_write  = 1'b1;
               state_nxt = S_DECODE;
            end
         end
         S_DECODE: begin
            alu_src_b = 2'b11;
            case (opcode)
               OP_LW, OP_SW: state_nxt = S_MEM_ADDR;
               OP_RTYPE:     state_nxt = S_EXECUTE;
               OP_BEQ:       state_nxt = S_BRANCH;
               OP_J:         state_nxt = S_JUMP;
               OP_ADDI:      state_nxt = S_ADDI_EXEC;
               default: begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
                  state_nxt = S_TRAP;
`else
                  state_nxt  = S_FETCH;
                  instr_done = 1'b1;
`endif
               end
            endcase
         end
         S_MEM_ADDR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            state_nxt = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
         end
         S_MEM_READ: begin
            mem_read = 1'b1;
            i_or_d   = 1'b1;
            if (mem_ready) state_nxt = S_MEM_WB;
         end
         S_MEM_WB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
            instr_done = 1'b1;
            state_nxt  = S_FETCH;
         end
         S_MEM_WRITE: begin
            mem_write = 1'b1;
            i_or_d    = 1'b1;
            if (mem_ready) begin
               instr_done = 1'b1;
               state_nxt  = S_FETCH;
            end
         end
         S_EXECUTE: begin
            alu_src_a = 1'b1;
            alu_op    = 2'b10;
            state_nxt = S_R_WB;
         end
         S_R_WB: begin
            reg_write  = 1'b1;
            reg_dst    = 1'b1;
            instr_done = 1'b1;
            state_nxt  = S_FETCH;
         end
         S_BRANCH: begin
            alu_src_a     = 1'b1;
            alu_op        = 2'b01;
            pc_write_cond = 1'b1;
            pc_source     = 2'b01;
            instr_done    = 1'b1;
            state_nxt     = S_FETCH;
         end
         S_JUMP: begin
            pc_write   = 1'b1;
            pc_source  = 2'b10;
            instr_done = 1'b1;
            state_nxt  = S_FETCH;
         end
         S_ADDI_EXEC: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            state_nxt = S_ADDI_WB;
         end
         S_ADDI_WB: begin
            reg_write  = 1'b1;
            instr_done = 1'b1;
            state_nxt  = S_FETCH;
         end
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
         S_TRAP: begin
            illegal_op = 1'b1;
            pc_write   = 1'b1;
            pc_source  = 2'b11;
            instr_done = 1'b1;
            state_nxt  = S_FETCH;
         end
`endif
         default: state_nxt = S_IDLE;
      endcase
      // A memory timeout overrides the state's own successor.
      if (timeout) begin
         bus_error = 1'b1;
         state_nxt = S_IDLE;
      end
   end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Testbench for multicycle_control_unit. A reference model steps through
// each instruction's state path. Directed scenarios run first, then
// randomized opcodes, mem_ready waits and resets.
module tb_multicycle_control_unit;

   localparam int TMO = 4;
   localparam int S_IDLE = 0, S_FETCH = 1, S_DECODE = 2, S_MEM_READ = 4, S_MEM_WB = 5,
                  S_MEM_WRITE = 6, S_MEM_ADDR = 3, S_EXECUTE = 7, S_R_WB = 8, S_BRANCH = 9,
                  S_JUMP = 10, S_ADDI_EXEC = 11, S_ADDI_WB = 12, S_TRAP = 13;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic [1:0] pc_source;
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       mem_to_reg;
      logic       reg_dst;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic       instr_done;
      logic       bus_error;
      logic       illegal_op;
   } ctl_t;

   typedef struct packed { logic rdy; logic rst; } stim_t;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] opcode;
   logic       mem_ready;
   logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
   logic       mem_to_reg, reg_dst, reg_write, alu_src_a, instr_done, bus_error, illegal_op;
   logic [1:0] pc_source, alu_src_b, alu_op;
   logic [3:0] state_o;

   multicycle_control_unit #(.MEM_TIMEOUT(TMO)) dut (
      .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
      .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
      .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
      .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
      .instr_done(instr_done), .bus_error(bus_error), .illegal_op(illegal_op),
      .state_o(state_o)
   );

   always #5 clk = ~clk;

   int n_checks = 0, n_errors = 0, cyc = 0;
   // Model: the current instruction's state path is packed one nibble per state.
   logic [31:0] p_seq;
   int          p_len = 0, idx = 0, wcnt = 0, lowrun = 0;
   bit          m_idle = 1'b1, m_need_op = 1'b0;
   logic [5:0]  m_op = 6'h00;
   stim_t       stq[$];
   logic [5:0]  opq[$];
   int          m_done = 0, m_berr = 0, m_ill = 0, o_done = 0, o_berr = 0, o_ill = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
      end
   endtask

   function automatic void build_path(input logic [5:0] op);
      case (op)
         6'h23:   begin p_seq = 32'h12345; p_len = 5; end
         6'h2B:   begin p_seq = 32'h1236;  p_len = 4; end
         6'h00:   begin p_seq = 32'h1278;  p_len = 4; end
         6'h04:   begin p_seq = 32'h129;   p_len = 3; end
         6'h02:   begin p_seq = 32'h12A;   p_len = 3; end
         6'h08:   begin p_seq = 32'h12BC;  p_len = 4; end
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
         default: begin p_seq = 32'h12D;   p_len = 3; end
`else
         default: begin p_seq = 32'h12;    p_len = 2; end
`endif
      endcase
   endfunction

   function automatic int path_at(input int i);
      logic [31:0] sh;
      sh = p_seq >> (4 * (p_len - 1 - i));
      return int'(sh[3:0]);
   endfunction

   function automatic ctl_t exp_ctl(input int s, input bit rdy, input bit last, input bit berr);
      ctl_t e = '0;
      case (s)
         S_FETCH:     begin e.mem_read = 1; e.alu_src_b = 2'b01; e.ir_write = rdy; e.pc_write = rdy; end
         S_DECODE:    e.alu_src_b = 2'b11;
         S_MEM_ADDR:  begin e.alu_src_a = 1; e.alu_src_b = 2'b10; end
         S_MEM_READ:  begin e.mem_read = 1; e.i_or_d = 1; end
         S_MEM_WB:    begin e.reg_write = 1; e.mem_to_reg = 1; end
         S_MEM_WRITE: begin e.mem_write = 1; e.i_or_d = 1; end
         S_EXECUTE:   begin e.alu_src_a = 1; e.alu_op = 2'b10; end
         S_R_WB:      begin e.reg_write = 1; e.reg_dst = 1; end
         S_BRANCH:    begin e.alu_src_a = 1; e.alu_op = 2'b01; e.pc_write_cond = 1; e.pc_source = 2'b01; end
         S_JUMP:      begin e.pc_write = 1; e.pc_source = 2'b10; end
         S_ADDI_EXEC: begin e.alu_src_a = 1; e.alu_src_b = 2'b10; end
         S_ADDI_WB:   e.reg_write = 1;
         S_TRAP:      begin e.illegal_op = 1; e.pc_write = 1; e.pc_source = 2'b11; end
         default:     e = '0;
      endcase
      // The final state of an instruction signals completion. A store completes only when memory is ready.
      e.instr_done = last && ((s != S_MEM_WRITE) || rdy);
      e.bus_error  = berr;
      return e;
   endfunction

   function automatic logic [5:0] rand_op();
      logic [5:0] r;
      case ($urandom_range(0, 7))
         0: r = 6'h00;
         1: r = 6'h23;
         2: r = 6'h2B;
         3: r = 6'h04;
         4: r = 6'h08;
         5: r = 6'h02;
         6: r = 6'($urandom);
         default: r = 6'h3F;
      endcase
      return r;
   endfunction

   task automatic rand_stim(output stim_t s);
      s.rst = ($urandom_range(0, 199) == 0);
      if (lowrun > 0) begin
         s.rdy = 1'b0;
         lowrun--;
      end else if ($urandom_range(0, 19) == 0) begin
         lowrun = $urandom_range(1, 6);
         s.rdy  = 1'b0;
      end else begin
         s.rdy = ($urandom_range(0, 3) != 0);
      end
   endtask

   task automatic start_instr();
      m_idle    = 1'b0;
      m_need_op = 1'b1;
      idx       = 0;
      wcnt      = 0;
   endtask

   task automatic push(input bit rdy, input bit rst, input int n);
      for (int i = 0; i < n; i++) stq.push_back({rdy, rst});
   endtask

   task automatic run_cycle();
      stim_t s;
      ctl_t  e, obs;
      int    cur;
      bit    last, mem, berr;
      @(negedge clk);
      if (stq.size() > 0) s = stq.pop_front();
      else rand_stim(s);
      if (!m_idle && m_need_op) begin
         m_op = (opq.size() > 0) ? opq.pop_front() : rand_op();
         build_path(m_op);
         m_need_op = 1'b0;
      end
      opcode    = m_op;
      mem_ready = s.rdy;
      reset     = s.rst;
      #1;
      cur  = m_idle ? S_IDLE : path_at(idx);
      last = !m_idle && (idx == p_len - 1);
      mem  = (cur == S_FETCH) || (cur == S_MEM_READ) || (cur == S_MEM_WRITE);
      berr = mem && !s.rdy && (TMO != 0) && (wcnt == TMO);
      e    = exp_ctl(cur, s.rdy, last, berr);
      obs  = {pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write, ir_write,
              mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
              instr_done, bus_error, illegal_op};
      check("state", {28'd0, state_o}, 32'(cur));
      check("outs", {12'd0, obs}, {12'd0, e});
      m_done += int'(e.instr_done);  m_berr += int'(e.bus_error);  m_ill += int'(e.illegal_op);
      o_done += int'(instr_done === 1'b1);
      o_berr += int'(bus_error === 1'b1);
      o_ill  += int'(illegal_op === 1'b1);
      if (s.rst) begin
         m_idle = 1'b1;
         wcnt   = 0;
      end else if (m_idle) begin
         start_instr();
      end else if (mem && !s.rdy) begin
         if (berr) begin
            m_idle = 1'b1;
            wcnt   = 0;
         end else begin
            wcnt++;
         end
      end else begin
         wcnt = 0;
         if (last) start_instr();
         else idx++;
      end
      cyc++;
   endtask

   task automatic run_queue();
      while (stq.size() > 0) run_cycle();
   endtask

   // Advance with memory always ready until the next cycle starts a new instruction.
   task automatic align();
      int n = 0;
      while (!(!m_idle && m_need_op) && n < 100) begin
         push(1'b1, 1'b0, 1);
         run_cycle();
         n++;
      end
      if (n >= 100) check("align_tmo", 32'd1, 32'd0);
   endtask

   initial begin
      reset     = 1'b1;
      mem_ready = 1'b0;
      opcode    = 6'h00;
      // Reset is held for three cycles and then released.
      push(1'b0, 1'b1, 3);
      push(1'b1, 1'b0, 1);
      run_queue();
      align();
      // LW with no wait states.
      opq.push_back(6'h23);
      push(1'b1, 1'b0, 5);
      run_queue();
      align();
      // SW that waits two cycles in MEM_WRITE.
      opq.push_back(6'h2B);
      push(1'b1, 1'b0, 3);
      push(1'b0, 1'b0, 2);
      push(1'b1, 1'b0, 1);
      run_queue();
      align();
      // R-type followed directly by BEQ.
      opq.push_back(6'h00);
      opq.push_back(6'h04);
      push(1'b1, 1'b0, 7);
      run_queue();
      align();
      // FETCH times out, goes through IDLE, then fetches again.
      opq.push_back(6'h08);
      push(1'b0, 1'b0, 5);
      push(1'b1, 1'b0, 3);
      run_queue();
      align();
      // Unknown opcode.
      opq.push_back(6'h3F);
      push(1'b1, 1'b0, 3);
      run_queue();
      align();
      // Reset arrives during EXECUTE.
      opq.push_back(6'h00);
      push(1'b1, 1'b0, 2);
      push(1'b1, 1'b1, 1);
      push(1'b1, 1'b0, 3);
      run_queue();
      // Random traffic.
      for (int i = 0; i < 3000; i++) run_cycle();
      check("n_done", 32'(o_done), 32'(m_done));
      check("n_berr", 32'(o_berr), 32'(m_berr));
      check("n_ill",  32'(o_ill),  32'(m_ill));
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Multicycle MIPS main control FSM; successor to the single-cycle opcode decoder.
- Sequences each instruction through fetch, decode, execute, memory and writeback states.
- Drives datapath mux selects and enables, and adds a memory ready handshake with a timeout.
- Sits between the instruction register (opcode source) and the shared memory, ALU, register file and PC datapath.

Parameters:
- OPCODE_W, 6, opcode width.
- OP_RTYPE, 6'h00, R-format opcode.
- OP_LW, 6'h23, load word.
- OP_SW, 6'h2B, store word.
- OP_BEQ, 6'h04, branch equal.
- OP_ADDI, 6'h08, add immediate.
- OP_J, 6'h02, jump.
- MEM_TIMEOUT, 16, maximum wait cycles in a memory state; 0 disables the timeout.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- opcode  in  OPCODE_W  instr[31:26] from IR; stable from DECODE until the instruction ends.
- mem_ready  in  1  memory completes the current access this cycle.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load if ALU zero.
- pc_source  out  2  00 ALU result, 01 ALUOut, 10 jump target, 11 exception vector.
- i_or_d  out  1  memory address: 0 PC, 1 ALUOut.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- ir_write  out  1  IR load.
- mem_to_reg  out  1  writeback source: 1 MDR.
- reg_dst  out  1  destination: 1 rd, 0 rt.
- reg_write  out  1  register file write.
- alu_src_a  out  1  0 PC, 1 A register.
- alu_src_b  out  2  00 B, 01 constant 4, 10 sign-extended immediate, 11 immediate shifted left 2.
- alu_op  out  2  00 add, 01 sub, 10 funct field decides.
- instr_done  out  1  one-cycle pulse in an instruction's final state.
- bus_error  out  1  one-cycle pulse on memory timeout.
- illegal_op  out  1  one-cycle pulse on trap (see optional feature).
- state_o  out  4  current state encoding, for debug.

Behaviour:
- Clock and reset: single clock domain, clk; synchronous, active-high reset.
- State encoding: IDLE=0, FETCH=1, DECODE=2, MEM_ADDR=3, MEM_READ=4, MEM_WB=5, MEM_WRITE=6, EXECUTE=7, R_WB=8, BRANCH=9, JUMP=10, ADDI_EXEC=11, ADDI_WB=12, TRAP=13.
- Reset: state goes to IDLE; every output is 0, including state_o=0. The wait counter clears.
- Reset mid-instruction: takes effect on the next edge regardless of state. No pending write completes.
- Output decode: outputs are a Moore decode of state. Exceptions: ir_write and pc_write in FETCH are additionally gated by mem_ready. All unlisted outputs are 0.
- IDLE: all outputs 0 → FETCH.
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00. When mem_ready=1: ir_write=1, pc_write=1, → DECODE. Otherwise stay.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00. Next state by opcode:
  - LW/SW → MEM_ADDR
  - RTYPE → EXECUTE
  - BEQ → BRANCH
  - J → JUMP
  - ADDI → ADDI_EXEC
  - anything else → see optional feature.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00 → MEM_READ if LW, else MEM_WRITE.
- MEM_READ: mem_read=1, i_or_d=1; wait for mem_ready → MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0, instr_done=1 → FETCH.
- MEM_WRITE: mem_write=1, i_or_d=1; wait for mem_ready, then instr_done=1 in that same cycle → FETCH.
- EXECUTE: alu_src_a=1, alu_src_b=00, alu_op=10 → R_WB.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0, instr_done=1 → FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01, instr_done=1 → FETCH.
- JUMP: pc_write=1, pc_source=10, instr_done=1 → FETCH.
- ADDI_EXEC: alu_src_a=1, alu_src_b=10, alu_op=00 → ADDI_WB.
- ADDI_WB: reg_write=1, reg_dst=0, mem_to_reg=0, instr_done=1 → FETCH.
- Latency without wait states:
  - LW 5 cycles, SW 4, R-type 4, ADDI 4, BEQ 3, J 3.
  - Each extra cycle with mem_ready=0 in FETCH, MEM_READ or MEM_WRITE adds one cycle.
- Wait counter:
  - Counts consecutive mem_ready=0 cycles in FETCH, MEM_READ or MEM_WRITE.
  - Clears on entry to any state and whenever mem_ready=1.
  - If MEM_TIMEOUT≠0 and the counter reaches MEM_TIMEOUT with mem_ready still 0: bus_error=1 for that cycle, next state IDLE.
  - mem_ready=1 in the same cycle the counter reaches MEM_TIMEOUT counts as completion, not timeout.
  - Counter width is $clog2(MEM_TIMEOUT+1); it saturates when MEM_TIMEOUT=0.
- mem_ready outside memory states: ignored.

Optional Feature:
- Macro: MC_CTRL_ILLEGAL_TRAP_EN.
- Defined: an unknown opcode in DECODE → TRAP. TRAP drives illegal_op=1, pc_write=1, pc_source=11, instr_done=1 → FETCH.
- Undefined: an unknown opcode in DECODE → FETCH as a no-op, with instr_done=1 in DECODE. TRAP is unreachable; illegal_op is tied 0.

Test Plan:
- Reset: hold reset high for 3 cycles, then release. Required: all outputs 0 and state_o=0 during reset; state_o=1 (FETCH) on the first cycle after release.
- LW, mem_ready always 1: state_o sequence 1,2,3,4,5. reg_write=1 and mem_to_reg=1 only in cycle 5; instr_done pulses once.
- SW with mem_ready low for 2 cycles in MEM_WRITE: MEM_WRITE lasts 3 cycles; mem_write=1 throughout; instr_done asserts in the third cycle; next state FETCH.
- R-type then BEQ back to back: R_WB has reg_dst=1, reg_write=1. BRANCH has pc_write_cond=1, pc_source=01, alu_op=01. Total 7 cycles.
- MEM_TIMEOUT=4, mem_ready held 0 in FETCH: bus_error pulses on the 5th FETCH cycle, then state_o=0 (IDLE), then FETCH. ir_write never asserts.
- Opcode 6'h3F, plus reset asserted during EXECUTE:
  - With MC_CTRL_ILLEGAL_TRAP_EN: TRAP with illegal_op=1, pc_source=11.
  - Without it: DECODE→FETCH with illegal_op=0.
  - Reset during EXECUTE: IDLE next cycle, reg_write never asserts.
